// File: rtl/crop_sequencer_pkg.sv
// Shared stream dtype codes and the crop sequencer FSM encoding.
// The dtype macros are the common definitions used by every stream block.
`ifndef CROP_DTYPES_SVH
`define CROP_DTYPES_SVH
`define DTYPE_WIDTH       4
`define DTYPE_NONE        4'h0
`define DTYPE_FRAME_START 4'h1
`define DTYPE_FRAME_END   4'h2
`define DTYPE_ROW_END     4'h4
`define DTYPE_PIXEL       4'h8
`define DTYPE_PIXEL_MASK  4'h8
`endif

package crop_sequencer_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FRAME = 1'b1
   } state_e;

   localparam int FRAME_CNT_W = 16;

   function automatic logic is_pixel(input logic [`DTYPE_WIDTH-1:0] dt);
      return (dt & `DTYPE_PIXEL_MASK) != '0;
   endfunction

endpackage

// File: rtl/crop_sequencer_frame_measure.sv
// Measures rows/cols of each complete input frame and counts finished frames.
// Strobes arrive pre-qualified by the sequencer FSM, so stray markers never reach here.
module frame_measure
   import crop_sequencer_pkg::*;
#(
   parameter int DIM_WIDTH = 12
) (
   input  logic                    clk,
   input  logic                    resetb,
   input  logic                    frame_start_i,
   input  logic                    frame_end_i,
   input  logic                    in_frame_i,
   input  logic                    dvi_i,
   input  logic [`DTYPE_WIDTH-1:0] dtype_i,
   output logic [DIM_WIDTH-1:0]    meas_rows_o,
   output logic [DIM_WIDTH-1:0]    meas_cols_o,
   output logic [FRAME_CNT_W-1:0]  frame_count_o
);

   logic [DIM_WIDTH-1:0]   row_cnt_q, row_cnt_d;
   logic [DIM_WIDTH-1:0]   pix_cnt_q, pix_cnt_d;
   logic [DIM_WIDTH-1:0]   meas_rows_q, meas_rows_d;
   logic [DIM_WIDTH-1:0]   meas_cols_q, meas_cols_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      row_cnt_d   = row_cnt_q;
      pix_cnt_d   = pix_cnt_q;
      meas_rows_d = meas_rows_q;
      meas_cols_d = meas_cols_q;
      frame_cnt_d = frame_cnt_q;
      if (frame_start_i) begin
         row_cnt_d = '0;
         pix_cnt_d = '0;
      end else if (in_frame_i && dvi_i) begin
         if (is_pixel(dtype_i))
            pix_cnt_d = pix_cnt_q + 1'b1;
         if (dtype_i == `DTYPE_ROW_END) begin
            meas_cols_d = pix_cnt_q;
            pix_cnt_d   = '0;
            row_cnt_d   = row_cnt_q + 1'b1;
         end
         if (frame_end_i) begin
            meas_rows_d = row_cnt_q;
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         row_cnt_q   <= '0;
         pix_cnt_q   <= '0;
         meas_rows_q <= '0;
         meas_cols_q <= '0;
         frame_cnt_q <= '0;
      end else begin
         row_cnt_q   <= row_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         meas_rows_q <= meas_rows_d;
         meas_cols_q <= meas_cols_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign meas_rows_o   = meas_rows_q;
   assign meas_cols_o   = meas_cols_q;
   assign frame_count_o = frame_cnt_q;

endmodule

// File: rtl/crop_sequencer.sv
// Crop config sequencer: takes host crop requests, holds them in a shadow
// and applies them only between frames after checking against measured size.
module crop_sequencer
   import crop_sequencer_pkg::*;
#(
   parameter int DIM_WIDTH = 12
) (
   input  logic                    clk,
   input  logic                    resetb,
   input  logic                    cfg_req,
   output logic                    cfg_ack,
   input  logic                    cfg_enable,
   input  logic [DIM_WIDTH-1:0]    cfg_rows,
   input  logic [DIM_WIDTH-1:0]    cfg_cols,
   input  logic                    dvi,
   input  logic [`DTYPE_WIDTH-1:0] dtypei,
   output logic                    crop_enable,
   output logic [DIM_WIDTH-1:0]    num_output_rows,
   output logic [DIM_WIDTH-1:0]    num_output_cols,
   output logic                    cfg_err,
   output logic [DIM_WIDTH-1:0]    meas_rows,
   output logic [DIM_WIDTH-1:0]    meas_cols,
   output logic [15:0]             frame_count,
   output logic                    in_frame
);

   typedef struct packed {
      logic                 en;
      logic [DIM_WIDTH-1:0] rows;
      logic [DIM_WIDTH-1:0] cols;
   } cfg_t;

   state_e state_q, state_d;
   cfg_t   shadow_q, shadow_d;
   cfg_t   applied_q, applied_d;
   logic   pending_q, pending_d;
   logic   ack_q, ack_d;
   logic   err_q, err_d;

   logic fs, fe, frame_start, frame_end, apply, rows_bad, cols_bad, cfg_bad;

   assign fs          = dvi && (dtypei == `DTYPE_FRAME_START);
   assign fe          = dvi && (dtypei == `DTYPE_FRAME_END);
   assign frame_start = fs && (state_q == ST_IDLE);
   assign frame_end   = fe && (state_q == ST_FRAME);

   // A start marker on the apply cycle wins: the config waits out the whole frame.
   assign apply = pending_q && (state_q == ST_IDLE) && !fs;

   // Crop must be symmetric, so the trimmed amount has to be even on each axis.
   assign rows_bad = (shadow_q.rows == '0)
                  || ((meas_rows != '0) && (shadow_q.rows > meas_rows))
                  || (meas_rows[0] ^ shadow_q.rows[0]);
   assign cols_bad = (shadow_q.cols == '0)
                  || ((meas_cols != '0) && (shadow_q.cols > meas_cols))
                  || (meas_cols[0] ^ shadow_q.cols[0]);
   assign cfg_bad  = shadow_q.en && (rows_bad || cols_bad);

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      applied_d = applied_q;
      pending_d = pending_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;

      case (state_q)
         ST_IDLE:  if (fs) state_d = ST_FRAME;
         ST_FRAME: if (fe) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (cfg_req && !pending_q) begin
         shadow_d  = '{en: cfg_enable, rows: cfg_rows, cols: cfg_cols};
         pending_d = 1'b1;
         ack_d     = 1'b1;
      end else if (apply) begin
         pending_d = 1'b0;
         if (cfg_bad)
            err_d = 1'b1;
         else
            applied_d = shadow_q;
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q   <= ST_IDLE;
         shadow_q  <= '0;
         applied_q <= '0;
         pending_q <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shadow_q  <= shadow_d;
         applied_q <= applied_d;
         pending_q <= pending_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
      end
   end

   frame_measure #(
      .DIM_WIDTH (DIM_WIDTH)
   ) u_measure (
      .clk           (clk),
      .resetb        (resetb),
      .frame_start_i (frame_start),
      .frame_end_i   (frame_end),
      .in_frame_i    (state_q == ST_FRAME),
      .dvi_i         (dvi),
      .dtype_i       (dtypei),
      .meas_rows_o   (meas_rows),
      .meas_cols_o   (meas_cols),
      .frame_count_o (frame_count)
   );

   assign cfg_ack         = ack_q;
   assign cfg_err         = err_q;
   assign crop_enable     = applied_q.en;
   assign num_output_rows = applied_q.rows;
   assign num_output_cols = applied_q.cols;
   assign in_frame        = (state_q == ST_FRAME);

endmodule

// File: tb/tb_crop_sequencer.sv
// Directed bench for crop_sequencer: stream beats stepped one per clock,
// outputs sampled 1ns after each rising edge against hand-computed values.
module tb_crop_sequencer;

   localparam int DW = 12;

   logic                    clk = 1'b0;
   logic                    resetb = 1'b0;
   logic                    cfg_req = 1'b0;
   logic                    cfg_enable = 1'b0;
   logic [DW-1:0]           cfg_rows = '0;
   logic [DW-1:0]           cfg_cols = '0;
   logic                    dvi = 1'b0;
   logic [`DTYPE_WIDTH-1:0] dtypei = `DTYPE_NONE;
   logic                    cfg_ack, crop_enable, cfg_err, in_frame;
   logic [DW-1:0]           num_output_rows, num_output_cols, meas_rows, meas_cols;
   logic [15:0]             frame_count;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_fc = 0;

   crop_sequencer #(.DIM_WIDTH(DW)) dut (
      .clk             (clk),
      .resetb          (resetb),
      .cfg_req         (cfg_req),
      .cfg_ack         (cfg_ack),
      .cfg_enable      (cfg_enable),
      .cfg_rows        (cfg_rows),
      .cfg_cols        (cfg_cols),
      .dvi             (dvi),
      .dtypei          (dtypei),
      .crop_enable     (crop_enable),
      .num_output_rows (num_output_rows),
      .num_output_cols (num_output_cols),
      .cfg_err         (cfg_err),
      .meas_rows       (meas_rows),
      .meas_cols       (meas_cols),
      .frame_count     (frame_count),
      .in_frame        (in_frame)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input logic dv, input logic [`DTYPE_WIDTH-1:0] dt);
      dvi    = dv;
      dtypei = dt;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic e_en, input int e_r, input int e_c);
      chk({tag, "_en"},   crop_enable, e_en);
      chk({tag, "_rows"}, num_output_rows, e_r);
      chk({tag, "_cols"}, num_output_cols, e_c);
   endtask

   task automatic row(input int nc);
      for (int i = 0; i < nc; i++) step(1'b1, `DTYPE_PIXEL);
      step(1'b1, `DTYPE_ROW_END);
   endtask

   task automatic frame_end();
      step(1'b1, `DTYPE_FRAME_END);
      exp_fc++;
   endtask

   task automatic set_cfg(input logic en, input int r, input int c);
      cfg_enable = en;
      cfg_rows   = r[DW-1:0];
      cfg_cols   = c[DW-1:0];
   endtask

   // Request issued in IDLE: ack one cycle later, apply/reject the cycle after.
   task automatic do_cfg(input string tag, input logic en, input int r, input int c,
                         input logic exp_err, input logic e_en, input int e_r, input int e_c);
      set_cfg(en, r, c);
      cfg_req = 1'b1;
      step(1'b0, `DTYPE_NONE);
      chk({tag, "_ack"}, cfg_ack, 1);
      chk_out({tag, "_pre"}, crop_enable, num_output_rows, num_output_cols);
      cfg_req = 1'b0;
      step(1'b0, `DTYPE_NONE);
      chk({tag, "_err"}, cfg_err, exp_err);
      chk({tag, "_ackclr"}, cfg_ack, 0);
      chk_out(tag, e_en, e_r, e_c);
      step(1'b0, `DTYPE_NONE);
      chk({tag, "_errclr"}, cfg_err, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack", cfg_ack, 0);
      chk("rst_err", cfg_err, 0);
      chk_out("rst", 0, 0, 0);
      chk("rst_mrows", meas_rows, 0);
      chk("rst_mcols", meas_cols, 0);
      chk("rst_fc", frame_count, 0);
      chk("rst_inframe", in_frame, 0);
      resetb = 1'b1;
      step(1'b0, `DTYPE_NONE);

      // 640x480 reference frame
      step(1'b1, `DTYPE_FRAME_START);
      chk("f1_inframe", in_frame, 1);
      for (int r = 0; r < 480; r++) row(640);
      frame_end();
      chk("f1_inframe_end", in_frame, 0);
      chk("f1_mrows", meas_rows, 480);
      chk("f1_mcols", meas_cols, 640);
      chk("f1_fc", frame_count, exp_fc);

      // stray FRAME_END in IDLE does nothing
      step(1'b1, `DTYPE_FRAME_END);
      chk("stray_fe_fc", frame_count, exp_fc);
      chk("stray_fe_inframe", in_frame, 0);

      do_cfg("c320x240",   1'b1, 240, 320, 1'b0, 1'b1, 240, 320);
      do_cfg("odd_cols",   1'b1, 240, 321, 1'b1, 1'b1, 240, 320);
      do_cfg("zero_rows",  1'b1,   0, 320, 1'b1, 1'b1, 240, 320);
      do_cfg("big_rows",   1'b1, 482, 320, 1'b1, 1'b1, 240, 320);
      do_cfg("odd_rows",   1'b1, 241, 320, 1'b1, 1'b1, 240, 320);
      do_cfg("big_cols",   1'b1, 240, 642, 1'b1, 1'b1, 240, 320);
      do_cfg("full_size",  1'b1, 480, 640, 1'b0, 1'b1, 480, 640);
      do_cfg("disable",    1'b0,   0,   0, 1'b0, 1'b0,   0,   0);

      // mid-frame request: acked at once, applied only after FRAME_END
      step(1'b1, `DTYPE_FRAME_START);
      row(6);
      set_cfg(1'b1, 2, 4);
      cfg_req = 1'b1;
      step(1'b0, `DTYPE_NONE);
      chk("mid_ack", cfg_ack, 1);
      cfg_req = 1'b0;
      step(1'b1, `DTYPE_FRAME_START);
      chk("dup_fs_inframe", in_frame, 1);
      for (int r = 0; r < 3; r++) row(6);
      chk_out("mid_hold", 0, 0, 0);
      frame_end();
      chk_out("mid_fe", 0, 0, 0);
      chk("mid_inframe", in_frame, 0);
      chk("mid_mrows", meas_rows, 4);
      chk("mid_mcols", meas_cols, 6);
      step(1'b0, `DTYPE_NONE);
      chk_out("mid_apply", 1, 2, 4);

      // back-to-back requests: B waits until A is applied
      step(1'b1, `DTYPE_FRAME_START);
      row(6);
      set_cfg(1'b0, 7, 9);
      cfg_req = 1'b1;
      step(1'b0, `DTYPE_NONE);
      chk("a_ack", cfg_ack, 1);
      set_cfg(1'b1, 2, 2);
      step(1'b0, `DTYPE_NONE);
      chk("b_held_ack", cfg_ack, 0);
      for (int r = 0; r < 3; r++) row(6);
      chk("b_held_ack2", cfg_ack, 0);
      frame_end();
      chk("b_held_ack3", cfg_ack, 0);
      chk_out("a_wait", 1, 2, 4);
      step(1'b0, `DTYPE_NONE);
      chk_out("a_apply", 0, 7, 9);
      chk("b_ack_late", cfg_ack, 0);
      step(1'b0, `DTYPE_NONE);
      chk("b_ack", cfg_ack, 1);
      cfg_req = 1'b0;
      // start collides with B's apply cycle: B waits out the whole frame
      step(1'b1, `DTYPE_FRAME_START);
      chk("b_fs_inframe", in_frame, 1);
      chk_out("b_blocked", 0, 7, 9);
      for (int r = 0; r < 4; r++) row(6);
      frame_end();
      chk_out("b_fe", 0, 7, 9);
      step(1'b0, `DTYPE_NONE);
      chk_out("b_apply", 1, 2, 2);
      chk("b_err", cfg_err, 0);

      // reset mid-frame with a config pending
      step(1'b1, `DTYPE_FRAME_START);
      row(6);
      set_cfg(1'b1, 4, 6);
      cfg_req = 1'b1;
      step(1'b0, `DTYPE_NONE);
      chk("rstp_ack", cfg_ack, 1);
      cfg_req = 1'b0;
      #2 resetb = 1'b0;
      #1;
      exp_fc = 0;
      chk_out("rstp_async", 0, 0, 0);
      chk("rstp_inframe", in_frame, 0);
      chk("rstp_ack0", cfg_ack, 0);
      chk("rstp_mrows", meas_rows, 0);
      chk("rstp_mcols", meas_cols, 0);
      chk("rstp_fc", frame_count, exp_fc);
      @(negedge clk);
      resetb = 1'b1;
      step(1'b0, `DTYPE_NONE);
      step(1'b0, `DTYPE_NONE);
      chk_out("rstp_lost", 0, 0, 0);
      chk("rstp_err", cfg_err, 0);
      chk("rstp_ack1", cfg_ack, 0);

      // frame_count wrap after 65536 empty frames
      for (int i = 0; i < 65535; i++) begin
         step(1'b1, `DTYPE_FRAME_START);
         frame_end();
      end
      chk("wrap_ffff", frame_count, 16'hFFFF);
      step(1'b1, `DTYPE_FRAME_START);
      frame_end();
      chk("wrap_zero", frame_count, 0);
      chk("wrap_mrows", meas_rows, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/crop_sequencer.md
CROP_SEQUENCER -- requirements
Module: crop_sequencer

Interface
REQ-001 SHALL have parameter DIM_WIDTH, default 12, the width of all row/column dimension signals.
REQ-002 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-003 SHALL have port resetb, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cfg_req, input, 1, host config request, level held until cfg_ack.
REQ-005 SHALL have port cfg_ack, output, 1, one-cycle pulse when the request is consumed.
REQ-006 SHALL have port cfg_enable, input, 1, requested crop enable.
REQ-007 SHALL have ports cfg_rows and cfg_cols, input, DIM_WIDTH each, requested output size.
REQ-008 SHALL have ports dvi (input, 1) and dtypei (input, `DTYPE_WIDTH), a monitored copy of the stream entering the crop datapath.
REQ-009 SHALL have port crop_enable, output, 1, applied enable driven to the crop datapath.
REQ-010 SHALL have ports num_output_rows and num_output_cols, output, DIM_WIDTH each, applied size.
REQ-011 SHALL have port cfg_err, output, 1, one-cycle pulse on a rejected request.
REQ-012 SHALL have ports meas_rows and meas_cols, output, DIM_WIDTH each, dimensions of the last complete input frame.
REQ-013 SHALL have port frame_count, output, 16, count of completed frames, wrapping from 0xFFFF to 0.
REQ-014 SHALL have port in_frame, output, 1, high while the FSM is in state FRAME.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and FRAME; with dvi=1, FRAME_START moves IDLE->FRAME and FRAME_END moves FRAME->IDLE.
REQ-016 SHALL ignore a FRAME_START received in FRAME and a FRAME_END received in IDLE; no state change results.
REQ-017 SHALL count ROW_END beats within a frame; on FRAME_END it SHALL load that count into meas_rows and increment frame_count.
REQ-018 SHALL count beats with (dtypei & `DTYPE_PIXEL_MASK) != 0 within a row; on ROW_END it SHALL load that count into meas_cols and clear the counter.
REQ-019 SHALL clear the row and pixel counters on FRAME_START; all counters SHALL use modulo-2^DIM_WIDTH arithmetic.
REQ-020 SHALL, when cfg_req=1 and no config is pending, capture cfg_enable, cfg_rows and cfg_cols into shadow registers, set pending, and pulse cfg_ack on the next cycle.
REQ-021 SHALL withhold cfg_ack while a config is pending; the held request is consumed on the cycle after pending clears.
REQ-022 SHALL apply a pending config (copy shadow to outputs, clear pending) only in IDLE and only on a cycle without dvi && FRAME_START.
REQ-023 SHALL keep a pending config pending for a whole frame when FRAME_START arrives on the same cycle it would otherwise apply; outputs SHALL stay constant throughout every frame.
REQ-024 SHALL reject a config at apply time if shadow enable=1 and any of the following holds: rows==0; cols==0; meas_rows!=0 with rows>meas_rows; meas_cols!=0 with cols>meas_cols; (meas_rows-rows) is odd; (meas_cols-cols) is odd.
REQ-025 SHALL, on rejection, pulse cfg_err, clear pending and leave all applied outputs unchanged.
REQ-026 SHALL accept a config with shadow enable=0 unconditionally; this drives crop_enable=0 and loads the size outputs.
REQ-027 SHALL add no combinational path from inputs to outputs; all outputs SHALL be registered.

Reset
REQ-028 SHALL, on resetb low, force state IDLE and clear to 0: pending, cfg_ack, cfg_err, crop_enable, num_output_rows, num_output_cols, meas_rows, meas_cols, frame_count and all counters.
REQ-029 SHALL drop a partial frame and its partial counts when reset is asserted mid-frame; measurement restarts at the next FRAME_START.

Structure
REQ-030 SHALL use the DTYPE codes and `DTYPE_WIDTH from the shared dtypes definitions; FSM state encodings SHALL live in the same shared package.
REQ-031 SHALL contain one sub-module, frame_measure, holding the counters and meas_rows/meas_cols/frame_count (REQ-017 to REQ-019).

Verification
REQ-032 SHALL cover: 640x480 frame then request enable=1, 320x240 in IDLE -> cfg_ack 1 cycle after req, outputs 1/320/240 on the following cycle.
REQ-033 SHALL cover: request issued mid-frame -> cfg_ack in 1 cycle, outputs unchanged until the cycle after FRAME_END.
REQ-034 SHALL cover: meas 640x480, request 321x240 -> cfg_err pulse, outputs unchanged.
REQ-035 SHALL cover: second request while first pending -> no second ack until first applied, then ack; both configs applied in order across frames.
REQ-036 SHALL cover: 65536 FRAME_START/FRAME_END pairs -> frame_count returns to 0.
REQ-037 SHALL cover: resetb pulsed mid-frame with a config pending -> all outputs 0, in_frame=0, pending lost.
